adc_stream_packer: RTL and testbench

Consumes the ASIC ADC's serial output (bit clock `CLK_S_D_OUT`, data `ADC_OUT`) in the `okClk` domain. Packs bits MSB-first into 32-bit words and buffers them in a FIFO. The FIFO drains through the host PipeOut at address 0xA1. The block sits between the ADC pins and the PipeOut, and replaces ad-hoc capture logic with a sized, flow-controlled stage that reports overflow.

---
 rtl/we_pkg.sv | 21 ++
 rtl/we_sync_fifo.sv | 90 +++++++++
 rtl/adc_stream_packer.sv | 164 ++++++++++++++++
 tb/tb_adc_stream_packer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/we_pkg.sv
// ---------------------------------------------------------------------------
// we_pkg
// Types and constants shared by the ADC stream packer and its FIFO.
//   state_t   : capture state machine encoding (IDLE, CAPTURE, DONE)
//   WORD_W    : packed word width
//   RST_*     : reset values for state and word-wide registers
// ---------------------------------------------------------------------------
package we_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam state_t            RST_STATE = IDLE;
    localparam logic [WORD_W-1:0] RST_WORD  = '0;

endpackage

// File: rtl/we_sync_fifo.sv
// ---------------------------------------------------------------------------
// we_sync_fifo
// Single-clock FIFO with a registered read port and a synchronous flush.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous flush (pointers and occupancy to zero)
//   wr/wdata : write strobe and data; dropped when full unless rd is also high
//   rd/rdata : read strobe; rdata updates the cycle after an accepted read
//              and holds otherwise (including reads while empty)
//   count    : occupancy 0..DEPTH
//   empty    : count == 0
//   full     : count == DEPTH
// ---------------------------------------------------------------------------
module we_sync_fifo
    import we_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic                     rd,
    output logic [WORD_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [WORD_W-1:0] r_rdata;

    logic w_empty;
    logic w_full;
    logic w_do_wr;
    logic w_do_rd;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // A write into a full FIFO is still legal when a read frees a slot in
    // the same cycle; a read from an empty FIFO is simply not performed.
    assign w_do_wr = wr && (!w_full || rd);
    assign w_do_rd = rd && !w_empty;

    // NOTE: storage arrays carry no reset; only pointers and count define
    // validity, and leaving the RAM unreset lets it map to block memory.
    always_ff @(posedge clk) begin
        if (w_do_wr && !clr) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= RST_WORD;
        end else if (w_do_rd && !clr) begin
            r_rdata <= r_mem[r_rd_ptr];
        end
    end

    assign rdata = r_rdata;
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;

endmodule

// File: rtl/adc_stream_packer.sv
// ---------------------------------------------------------------------------
// adc_stream_packer
// Samples the ADC serial stream (clk_s_d / adc_dout, asynchronous) in the clk
// domain, packs bits MSB-first into 32-bit words and queues them in a FIFO
// drained by the host PipeOut.
//   clk, rst        : system clock, synchronous active-high reset
//   start / abort   : one-cycle control pulses (start wins if both)
//   nsam            : words to capture, latched on start
//   clk_s_d, adc_dout : ADC bit clock and data (asynchronous)
//   rd / dout       : PipeOut read strobe, 1-cycle registered read data
//   count/empty/full: FIFO status
//   busy, done, done_pulse : capture status
//   overflow, underflow    : sticky error flags, cleared by start
// ---------------------------------------------------------------------------
module adc_stream_packer
    import we_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [31:0]              nsam,
    input  logic                     clk_s_d,
    input  logic                     adc_dout,
    input  logic                     rd,
    output logic [WORD_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     busy,
    output logic                     done,
    output logic                     done_pulse,
    output logic                     overflow,
    output logic                     underflow
);

    // Clock and data go through identical chains so the sample taken on a
    // detected edge is the bit that was present at that pin edge.
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;

    state_t            r_state;
    state_t            w_state_next;
    logic [WORD_W-1:0] r_shreg;
    logic [4:0]        r_bitcnt;
    logic [31:0]       r_wordcnt;
    logic [31:0]       r_nsam_q;
    logic              r_overflow;
    logic              r_underflow;
    logic              r_done_pulse;

    logic              w_sample;
    logic              w_bit;
    logic              w_capture;
    logic              w_word_end;
    logic [WORD_W-1:0] w_word;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= '0;
            r_dat_sync <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], clk_s_d};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], adc_dout};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sample = r_clk_sync[SYNC_STAGES-1] && !r_clk_prev;
    assign w_bit    = r_dat_sync[SYNC_STAGES-1];

    // A control pulse in the same cycle as a sample takes priority; the
    // sample is discarded.
    assign w_capture  = (r_state == CAPTURE) && w_sample && !start && !abort;
    assign w_word_end = w_capture && (r_bitcnt == 5'd31);
    assign w_word     = {r_shreg[WORD_W-2:0], w_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment at the top of the combinational block
    // covers every path, so no latch can be inferred for the next state.
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = (nsam != 32'd0) ? CAPTURE : DONE;
        end else if (abort) begin
            w_state_next = IDLE;
        end else if (w_word_end && ((r_wordcnt + 32'd1) == r_nsam_q)) begin
            w_state_next = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg      <= RST_WORD;
            r_bitcnt     <= '0;
            r_wordcnt    <= '0;
            r_nsam_q     <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            // Restarting with nsam=0 from DONE counts as a fresh entry.
            r_done_pulse <= (w_state_next == DONE) && ((r_state != DONE) || start);
            if (start) begin
                r_shreg     <= RST_WORD;
                r_bitcnt    <= '0;
                r_wordcnt   <= '0;
                r_nsam_q    <= nsam;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (abort) begin
                    r_shreg  <= RST_WORD;
                    r_bitcnt <= '0;
                end else if (w_capture) begin
                    r_shreg  <= w_word;
                    r_bitcnt <= r_bitcnt + 5'd1;
                    // The word period counts even if the FIFO drops the word.
                    if (w_word_end) r_wordcnt <= r_wordcnt + 32'd1;
                end
                if (w_word_end && w_fifo_full && !rd) r_overflow  <= 1'b1;
                if (rd && w_fifo_empty)               r_underflow <= 1'b1;
            end
        end
    end

    we_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .wr    (w_word_end),
        .wdata (w_word),
        .rd    (rd),
        .rdata (dout),
        .count (count),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign empty      = w_fifo_empty;
    assign full       = w_fifo_full;
    assign busy       = (r_state == CAPTURE);
    assign done       = (r_state == DONE);
    assign done_pulse = r_done_pulse;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_adc_stream_packer.sv
// ---------------------------------------------------------------------------
// tb_adc_stream_packer
// Self-checking bench for adc_stream_packer (DEPTH=4). Words expected in the
// FIFO are queued as they are serialised onto the ADC pins and compared as
// the PipeOut side reads them back.
// ---------------------------------------------------------------------------
module tb_adc_stream_packer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [31:0]   nsam;
    logic          clk_s_d;
    logic          adc_dout;
    logic          rd;
    logic [31:0]   dout;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          busy;
    logic          done;
    logic          done_pulse;
    logic          overflow;
    logic          underflow;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          pulse_cnt = 0;
    int          pc0;
    logic [31:0] sb [$];
    logic [31:0] last_word = 32'd0;

    adc_stream_packer #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .nsam       (nsam),
        .clk_s_d    (clk_s_d),
        .adc_dout   (adc_dout),
        .rd         (rd),
        .dout       (dout),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_pulse === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] n);
        nsam  = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.delete();
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] exp;
        exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        last_word = exp;
        check(tag, dout, exp);
    endtask

    task automatic do_read(input string tag);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        pop_check(tag);
    endtask

    // One bit period = 10 clk: 5 low, 5 high. With two sync stages the
    // shift (and any FIFO write) lands on the 3rd clk edge after the pin
    // rises; rd_at_write raises rd for exactly that edge.
    task automatic send_bit(input logic b, input bit rd_at_write);
        adc_dout = b;
        clk_s_d  = 1'b0;
        repeat (5) tick();
        clk_s_d = 1'b1;
        tick();
        tick();
        if (rd_at_write) rd = 1'b1;
        tick();
        rd = 1'b0;
        if (rd_at_write) pop_check("rd_at_full_write");
        tick();
        tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit push, input bit rd_last);
        for (int i = 31; i >= 0; i--) begin
            send_bit(w[i], rd_last && (i == 0));
        end
        if (push) sb.push_back(w);
    endtask

    task automatic send_rand_bits(input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        nsam     = 32'd0;
        clk_s_d  = 1'b0;
        adc_dout = 1'b0;
        rd       = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_busy",      32'(busy),       32'd0);
        check("rst_done",      32'(done),       32'd0);
        check("rst_done_pulse",32'(done_pulse), 32'd0);
        check("rst_count",     32'(count),      32'd0);
        check("rst_empty",     32'(empty),      32'd1);
        check("rst_full",      32'(full),       32'd0);
        check("rst_overflow",  32'(overflow),   32'd0);
        check("rst_underflow", 32'(underflow),  32'd0);
        check("rst_dout",      dout,            32'd0);
        rst = 1'b0;
        tick();

        // Case 1: two words, then two reads
        pc0 = pulse_cnt;
        pulse_start(32'd2);
        check("c1_busy_after_start",  32'(busy),  32'd1);
        check("c1_count_after_start", 32'(count), 32'd0);
        send_word(32'hA5A5_A5A5, 1'b1, 1'b0);
        check("c1_count_1", 32'(count), 32'd1);
        check("c1_done_0",  32'(done),  32'd0);
        send_word(32'h0000_FFFF, 1'b1, 1'b0);
        check("c1_count_2", 32'(count), 32'd2);
        check("c1_done_1",  32'(done),  32'd1);
        check("c1_busy_0",  32'(busy),  32'd0);
        check("c1_pulses",  32'(pulse_cnt - pc0), 32'd1);
        do_read("c1_rd0");
        do_read("c1_rd1");
        check("c1_count_0", 32'(count), 32'd0);
        check("c1_empty",   32'(empty), 32'd1);

        // Case 2: overflow with DEPTH=4, nsam=6, no reads
        pc0 = pulse_cnt;
        pulse_start(32'd6);
        for (int i = 0; i < 6; i++) begin
            send_word(32'hC0DE_0000 | 32'(i * 32'h1111), i < 4, 1'b0);
            if (i == 3) check("c2_no_ovf_yet", 32'(overflow), 32'd0);
        end
        check("c2_count",    32'(count),    32'd4);
        check("c2_full",     32'(full),     32'd1);
        check("c2_overflow", 32'(overflow), 32'd1);
        check("c2_done",     32'(done),     32'd1);
        check("c2_busy",     32'(busy),     32'd0);
        check("c2_pulses",   32'(pulse_cnt - pc0), 32'd1);
        for (int i = 0; i < 4; i++) do_read("c2_drain");
        check("c2_empty",       32'(empty),    32'd1);
        check("c2_ovf_sticky",  32'(overflow), 32'd1);

        // Case 3: abort mid-word, later edges ignored, restart flushes
        pulse_start(32'd3);
        check("c3_ovf_cleared", 32'(overflow), 32'd0);
        send_word(32'h1234_5678, 1'b1, 1'b0);
        send_rand_bits(8);
        pulse_abort();
        check("c3_busy",  32'(busy),  32'd0);
        check("c3_done",  32'(done),  32'd0);
        check("c3_count", 32'(count), 32'd1);
        send_rand_bits(20);
        check("c3_count_idle", 32'(count), 32'd1);
        check("c3_busy_idle",  32'(busy),  32'd0);
        pulse_start(32'd3);
        check("c3_flush_count", 32'(count), 32'd0);
        check("c3_flush_empty", 32'(empty), 32'd1);
        check("c3_rearmed",     32'(busy),  32'd1);
        pulse_abort();
        check("c3_abort_again", 32'(busy), 32'd0);

        // Case 4: read while empty
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("c4_underflow", 32'(underflow), 32'd1);
        check("c4_dout_held", dout,           last_word);
        check("c4_count",     32'(count),     32'd0);
        pulse_start(32'd1);
        check("c4_udf_cleared", 32'(underflow), 32'd0);
        send_word(32'h5A5A_C3C3, 1'b1, 1'b0);
        check("c4_done", 32'(done), 32'd1);
        do_read("c4_rd");

        // Case 5: write and read in the same cycle while full
        pulse_start(32'd5);
        for (int i = 0; i < 4; i++) begin
            send_word(32'h0BAD_F00D ^ 32'(i << 8), 1'b1, 1'b0);
        end
        check("c5_full_before", 32'(full), 32'd1);
        send_word(32'h7777_1234, 1'b1, 1'b1);
        check("c5_count",    32'(count),    32'd4);
        check("c5_full",     32'(full),     32'd1);
        check("c5_overflow", 32'(overflow), 32'd0);
        check("c5_done",     32'(done),     32'd1);
        for (int i = 0; i < 4; i++) do_read("c5_drain");
        check("c5_empty", 32'(empty), 32'd1);

        // Case 6: reset mid-capture, then start with nsam=0
        pulse_start(32'd2);
        send_rand_bits(10);
        check("c6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("c6_busy",      32'(busy),      32'd0);
        check("c6_done",      32'(done),      32'd0);
        check("c6_count",     32'(count),     32'd0);
        check("c6_empty",     32'(empty),     32'd1);
        check("c6_overflow",  32'(overflow),  32'd0);
        check("c6_underflow", 32'(underflow), 32'd0);
        check("c6_dout",      dout,           32'd0);
        pc0 = pulse_cnt;
        nsam  = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c6_done_pulse", 32'(done_pulse), 32'd1);
        check("c6_done_n0",    32'(done),       32'd1);
        check("c6_busy_n0",    32'(busy),       32'd0);
        check("c6_count_n0",   32'(count),      32'd0);
        tick();
        check("c6_pulse_low",  32'(done_pulse), 32'd0);
        check("c6_done_hold",  32'(done),       32'd1);
        check("c6_pulses",     32'(pulse_cnt - pc0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
